// File: rtl/conv_matrix_printer.sv
// Streams a snapshotted ROWSxCOLS matrix of unsigned elements as decimal ASCII text
// to a byte-wide UART transmitter, then pulses print_done back to the engine.
module conv_matrix_printer #(
   parameter int ROWS = 8,
   parameter int COLS = 10,
   parameter int DW   = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     print_enable,
   input  logic [ROWS*COLS*DW-1:0]  matrix_data,
   output logic                     print_done,
   output logic                     busy,
   output logic [7:0]               tx_data,
   output logic                     tx_start,
   input  logic                     tx_busy
);

   localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_CONVERT, S_SEND_DIGIT, S_SEND_SEP, S_SEND_CR, S_SEND_LF, S_DONE
   } state_t;

   typedef enum logic [1:0] {H_WAIT, H_RISE, H_FALL} hs_t;

   state_t                    r_state;
   state_t                    w_nextState;
   hs_t                       r_hs;
   logic                      r_riseCnt;
   logic                      r_armed;
   logic [ROWS*COLS*DW-1:0]   r_snap;
   logic [16:0]               r_rem;
   logic [2:0]                r_place;
   logic [3:0]                r_digCnt;
   logic [3:0]                r_digits [0:4];
   logic [2:0]                r_first;
   logic                      r_seenNz;
   logic [2:0]                r_dIdx;
   logic [COL_W-1:0]          r_col;
   logic [ROW_W-1:0]          r_row;

   logic                      w_start;
   logic                      w_inSend;
   logic                      w_txStart;
   logic                      w_byteDone;
   logic [16:0]               w_placeVal;
   logic                      w_canSub;
   logic                      w_convDone;
   logic                      w_lastCol;
   logic                      w_lastRow;
   logic                      w_loadNext;
   logic [7:0]                w_byte;

   function automatic logic [16:0] placeValue(input logic [2:0] p);
      case (p)
         3'd0:    placeValue = 17'd10000;
         3'd1:    placeValue = 17'd1000;
         3'd2:    placeValue = 17'd100;
         3'd3:    placeValue = 17'd10;
         default: placeValue = 17'd1;
      endcase
   endfunction

   assign w_start    = (r_state == S_IDLE) && print_enable && r_armed;
   assign w_inSend   = (r_state == S_SEND_DIGIT) || (r_state == S_SEND_SEP) ||
                       (r_state == S_SEND_CR)    || (r_state == S_SEND_LF);
   // tx_start is gated directly by tx_busy so it can never overlap a busy transmitter
   assign w_txStart  = w_inSend && (r_hs == H_WAIT) && !tx_busy;
   assign w_byteDone = w_inSend && (r_hs == H_FALL) && !tx_busy;
   assign w_placeVal = placeValue(r_place);
   assign w_canSub   = (r_rem >= w_placeVal);
   assign w_convDone = (r_state == S_CONVERT) && !w_canSub && (r_place == 3'd4);
   assign w_lastCol  = (r_col == COL_W'(COLS - 1));
   assign w_lastRow  = (r_row == ROW_W'(ROWS - 1));
   assign w_loadNext = w_byteDone &&
                       ((r_state == S_SEND_SEP) || ((r_state == S_SEND_LF) && !w_lastRow));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         S_IDLE:       if (w_start) w_nextState = S_CONVERT;
         S_CONVERT:    if (w_convDone) w_nextState = S_SEND_DIGIT;
         S_SEND_DIGIT: if (w_byteDone && (r_dIdx == 3'd4))
                          w_nextState = w_lastCol ? S_SEND_CR : S_SEND_SEP;
         S_SEND_SEP:   if (w_byteDone) w_nextState = S_CONVERT;
         S_SEND_CR:    if (w_byteDone) w_nextState = S_SEND_LF;
         S_SEND_LF:    if (w_byteDone) w_nextState = w_lastRow ? S_DONE : S_CONVERT;
         S_DONE:       w_nextState = S_IDLE;
         default:      w_nextState = S_IDLE;
      endcase
   end

   always_comb begin
      w_byte = 8'h00;
      case (r_state)
         S_SEND_DIGIT: w_byte = 8'h30 + {4'h0, r_digits[r_dIdx]};
         S_SEND_SEP:   w_byte = 8'h20;
         S_SEND_CR:    w_byte = 8'h0D;
         S_SEND_LF:    w_byte = 8'h0A;
         default:      w_byte = 8'h00;
      endcase
      tx_start   = w_txStart;
      tx_data    = w_txStart ? w_byte : 8'h00;
      busy       = (r_state != S_IDLE) && (r_state != S_DONE);
      print_done = (r_state == S_DONE);
   end

   // Byte handshake: wait idle, pulse start, wait for the rise (2-cycle timeout), wait for the fall
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hs      <= H_WAIT;
         r_riseCnt <= 1'b0;
      end else if (!w_inSend) begin
         r_hs      <= H_WAIT;
         r_riseCnt <= 1'b0;
      end else begin
         case (r_hs)
            H_WAIT: if (w_txStart) begin
               r_hs      <= H_RISE;
               r_riseCnt <= 1'b0;
            end
            H_RISE: if (tx_busy || r_riseCnt) r_hs <= H_FALL;
                    else r_riseCnt <= 1'b1;
            H_FALL: if (!tx_busy) r_hs <= H_WAIT;
            default: r_hs <= H_WAIT;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_armed <= 1'b1;
      end else if (!print_enable) begin
         r_armed <= 1'b1;
      end else if (w_start) begin
         r_armed <= 1'b0;
      end
   end

   // The snapshot is consumed as a shift register so the current element is always its low word
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_snap   <= '0;
         r_rem    <= '0;
         r_place  <= '0;
         r_digCnt <= '0;
         r_first  <= 3'd4;
         r_seenNz <= 1'b0;
         r_dIdx   <= 3'd4;
         r_col    <= '0;
         r_row    <= '0;
         for (int i = 0; i < 5; i++) r_digits[i] <= '0;
      end else if (w_start) begin
         r_snap   <= matrix_data;
         r_rem    <= {1'b0, matrix_data[DW-1:0]};
         r_place  <= '0;
         r_digCnt <= '0;
         r_first  <= 3'd4;
         r_seenNz <= 1'b0;
         r_col    <= '0;
         r_row    <= '0;
      end else if (w_loadNext) begin
         r_snap   <= r_snap >> DW;
         r_rem    <= {1'b0, r_snap[2*DW-1:DW]};
         r_place  <= '0;
         r_digCnt <= '0;
         r_first  <= 3'd4;
         r_seenNz <= 1'b0;
         if (r_state == S_SEND_SEP) begin
            r_col <= r_col + 1'b1;
         end else begin
            r_col <= '0;
            r_row <= r_row + 1'b1;
         end
      end else if (r_state == S_CONVERT) begin
         if (w_canSub) begin
            r_rem    <= r_rem - w_placeVal;
            r_digCnt <= r_digCnt + 1'b1;
         end else begin
            r_digits[r_place] <= r_digCnt;
            r_digCnt          <= '0;
            if ((r_digCnt != 4'd0) && !r_seenNz) begin
               r_seenNz <= 1'b1;
               r_first  <= r_place;
            end
            if (r_place == 3'd4) begin
               r_dIdx <= r_first;
            end else begin
               r_place <= r_place + 1'b1;
            end
         end
      end else if ((r_state == S_SEND_DIGIT) && w_byteDone && (r_dIdx != 3'd4)) begin
         r_dIdx <= r_dIdx + 1'b1;
      end
   end

endmodule

// File: tb/tb_conv_matrix_printer.sv
// Randomized bench for conv_matrix_printer: a UART model captures the byte stream and
// a text-formatting reference model produces the expected bytes for each print.
module tb_conv_matrix_printer;

   localparam int ROWS = 8;
   localparam int COLS = 10;
   localparam int DW   = 16;
   localparam int NEL  = ROWS * COLS;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                print_enable = 1'b0;
   logic [NEL*DW-1:0]   matrix_data = '0;
   logic                print_done;
   logic                busy;
   logic [7:0]          tx_data;
   logic                tx_start;
   logic                tx_busy;
   logic                holdBusy = 1'b0;
   logic                modelBusy = 1'b0;

   logic [7:0]          rxQ [$];
   logic [7:0]          expQ [$];
   logic [15:0]         mat [NEL];

   int assertCount = 0;
   int failCount   = 0;
   int busyLen     = 10;
   int busyCnt     = 0;
   int doneCnt     = 0;
   int doneBusyCnt = 0;
   int startBusyCnt = 0;

   assign tx_busy = holdBusy | modelBusy;

   conv_matrix_printer #(.ROWS(ROWS), .COLS(COLS), .DW(DW)) dut (
      .clk          (clk),
      .rst          (rst),
      .print_enable (print_enable),
      .matrix_data  (matrix_data),
      .print_done   (print_done),
      .busy         (busy),
      .tx_data      (tx_data),
      .tx_start     (tx_start),
      .tx_busy      (tx_busy)
   );

   always #5 clk = ~clk;

   // UART model and protocol monitor, sampled on the falling edge
   always @(negedge clk) begin
      if (rst) begin
         busyCnt = 0;
      end else begin
         if (print_done) begin
            doneCnt++;
            if (busy) doneBusyCnt++;
         end
         if (tx_start) begin
            rxQ.push_back(tx_data);
            if (tx_busy) startBusyCnt++;
            busyCnt = busyLen;
         end else if (busyCnt > 0) begin
            busyCnt--;
         end
      end
      modelBusy = (busyCnt > 0);
   end

   initial begin
      #950000;
      $display("[TB] FAIL watchdog: simulation time exhausted");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed %0d (0x%0h), required %0d (0x%0h)", tag, observed, observed, expected, expected);
      end
   endtask

   task automatic applyStimulus();
      for (int k = 0; k < NEL; k++) matrix_data[k*DW +: DW] = mat[k];
   endtask

   task automatic randomMatrix();
      for (int k = 0; k < NEL; k++) begin
         case ($urandom % 4)
            0:       mat[k] = 16'd0;
            1:       mat[k] = 16'hFFFF;
            default: mat[k] = 16'($urandom_range(0, 65535));
         endcase
      end
   endtask

   // Reference: each row is the decimal elements joined by spaces, terminated by CR LF
   task automatic buildExpected();
      string s;
      expQ.delete();
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            s = $sformatf("%0d", mat[r*COLS + c]);
            for (int i = 0; i < s.len(); i++) expQ.push_back(s[i]);
            if (c < COLS - 1) expQ.push_back(8'h20);
         end
         expQ.push_back(8'h0D);
         expQ.push_back(8'h0A);
      end
   endtask

   task automatic compareStream(input string tag);
      checkOutput({tag, "/byteCount"}, rxQ.size(), expQ.size());
      for (int i = 0; i < expQ.size() && i < rxQ.size(); i++) begin
         checkOutput($sformatf("%s/byte%0d", tag, i), rxQ[i], expQ[i]);
         if (rxQ[i] !== expQ[i]) break;
      end
   endtask

   task automatic waitDone(input string tag, input int base, input int budget);
      int n = 0;
      while (doneCnt == base && n < budget) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      checkOutput({tag, "/donePulses"}, doneCnt - base, 1);
   endtask

   task automatic runStream(input string tag, input bit changeAfter, input int holdCycles);
      int base = doneCnt;
      buildExpected();
      rxQ.delete();
      @(negedge clk);
      if (holdCycles > 0) holdBusy = 1'b1;
      print_enable = 1'b1;
      if (changeAfter) begin
         @(negedge clk);
         @(negedge clk);
         randomMatrix();
         applyStimulus();
      end
      if (holdCycles > 0) begin
         repeat (holdCycles) @(negedge clk);
         checkOutput({tag, "/noStartWhileHeld"}, rxQ.size(), 0);
         holdBusy = 1'b0;
      end
      waitDone(tag, base, 20000);
      compareStream(tag);
   endtask

   function automatic string lineText(input int lineNo);
      string s = "";
      int ln = 0;
      for (int i = 0; i < rxQ.size(); i++) begin
         if (ln == lineNo) s = {s, string'(rxQ[i])};
         if (rxQ[i] == 8'h0A) ln++;
      end
      return s;
   endfunction

   initial begin
      int base;
      int cut;
      int n;
      string ln;

      repeat (3) @(negedge clk);
      checkOutput("reset/busy", busy, 0);
      checkOutput("reset/print_done", print_done, 0);
      checkOutput("reset/tx_start", tx_start, 0);
      checkOutput("reset/tx_data", tx_data, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      $display("[TB] all-zero matrix");
      for (int k = 0; k < NEL; k++) mat[k] = 16'd0;
      applyStimulus();
      busyLen = 10;
      runStream("zero", 1'b0, 0);
      checkOutput("zero/168bytes", rxQ.size(), 168);
      ln = lineText(4);
      checkOutput("zero/line4", ln == "0 0 0 0 0 0 0 0 0 0\r\n", 1);
      print_enable = 1'b0;

      $display("[TB] boundary pattern");
      for (int k = 0; k < NEL; k++) mat[k] = 16'd0;
      mat[0] = 16'd65535; mat[9] = 16'd10; mat[10] = 16'd100; mat[79] = 16'd7;
      applyStimulus();
      busyLen = 3;
      runStream("pattern", 1'b0, 0);
      ln = lineText(0);
      checkOutput("pattern/line0", ln == "65535 0 0 0 0 0 0 0 0 10\r\n", 1);
      ln = lineText(1);
      checkOutput("pattern/line1start", ln.substr(0, 3) == "100 ", 1);
      ln = lineText(7);
      checkOutput("pattern/line7end", ln.substr(ln.len() - 5, ln.len() - 1) == "0 7\r\n", 1);
      print_enable = 1'b0;

      $display("[TB] transmitter held busy before first byte");
      randomMatrix();
      applyStimulus();
      runStream("heldBusy", 1'b0, 5000);

      $display("[TB] print_enable held high after print_done");
      base = doneCnt;
      rxQ.delete();
      repeat (300) @(negedge clk);
      checkOutput("hold/noBytes", rxQ.size(), 0);
      checkOutput("hold/noDone", doneCnt - base, 0);
      checkOutput("hold/busyLow", busy, 0);
      print_enable = 1'b0;
      randomMatrix();
      applyStimulus();
      runStream("rearm", 1'b0, 0);
      print_enable = 1'b0;

      $display("[TB] reset during row 3");
      randomMatrix();
      applyStimulus();
      buildExpected();
      cut = 0;
      n = 0;
      for (int i = 0; i < expQ.size(); i++) begin
         if (expQ[i] == 8'h0A) begin
            n++;
            if (n == 3) begin
               cut = i + 1;
               break;
            end
         end
      end
      rxQ.delete();
      @(negedge clk);
      print_enable = 1'b1;
      n = 0;
      while (rxQ.size() < cut + 3 && n < 20000) begin
         @(negedge clk);
         n++;
      end
      checkOutput("reset/reachedRow3", rxQ.size() >= cut + 3, 1);
      #2 rst = 1'b1;
      #1;
      checkOutput("midReset/tx_start", tx_start, 0);
      checkOutput("midReset/busy", busy, 0);
      checkOutput("midReset/print_done", print_done, 0);
      print_enable = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      randomMatrix();
      applyStimulus();
      runStream("afterReset", 1'b0, 0);
      print_enable = 1'b0;

      $display("[TB] matrix_data changed after snapshot");
      randomMatrix();
      applyStimulus();
      runStream("snapshot", 1'b1, 0);
      print_enable = 1'b0;
      repeat (5) @(negedge clk);

      checkOutput("protocol/busyLowAtDone", doneBusyCnt, 0);
      checkOutput("protocol/startWhileBusy", startBusyCnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
